// File: rtl/regfile_cmd_ctrl.sv
// Register-file command controller: parses framed RX bytes into register writes/reads
// and returns read data to the TX path, with inter-byte and read-response timeouts.
module regfile_cmd_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] WR_CMD      = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD      = 8'hBB,
   parameter int                    TIMEOUT_CYC = 64,
   parameter int                    RD_TIMEOUT  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_D,
   input  logic                  RX_D_VLD,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   input  logic [DATA_WIDTH-1:0] RF_RdData,
   input  logic                  RF_RdData_VLD,
   output logic [DATA_WIDTH-1:0] TX_D,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  CMD_ERR,
   output logic                  BUSY
);

   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   localparam int RCW = $clog2(RD_TIMEOUT + 1);
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYC);
   localparam logic [RCW-1:0] RD_LAST = RCW'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
   } state_t;

   state_t                  state, state_nx;
   logic [TCW-1:0]          to_cnt, to_cnt_nx;
   logic [RCW-1:0]          rd_cnt, rd_cnt_nx;
   logic [ADDR_WIDTH-1:0]   addr_nx;
   logic [DATA_WIDTH-1:0]   wdata_nx, txd_nx;
   logic                    tx_vld_nx, err_nx;
   logic                    addr_ok;

   assign addr_ok = (RX_D[DATA_WIDTH-1:ADDR_WIDTH] == '0);

   always_comb begin
      state_nx  = state;
      to_cnt_nx = '0;
      rd_cnt_nx = '0;
      addr_nx   = RF_Address;
      wdata_nx  = RF_WrData;
      txd_nx    = TX_D;
      tx_vld_nx = 1'b0;
      err_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_D == WR_CMD)      state_nx = WR_ADDR;
               else if (RX_D == RD_CMD) state_nx = RD_ADDR;
               else                     err_nx   = 1'b1;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (RX_D_VLD) begin
               if (!addr_ok) begin
                  err_nx   = 1'b1;
                  state_nx = IDLE;
               end else begin
                  addr_nx  = RX_D[ADDR_WIDTH-1:0];
                  state_nx = (state == WR_ADDR) ? WR_DATA : RD_EXEC;
               end
            end else if (to_cnt == TO_LAST) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               to_cnt_nx = to_cnt + 1'b1;
            end
         end
         WR_DATA: begin
            // a byte arriving on the expiry cycle still completes the frame
            if (RX_D_VLD) begin
               wdata_nx = RX_D;
               state_nx = WR_EXEC;
            end else if (to_cnt == TO_LAST) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               to_cnt_nx = to_cnt + 1'b1;
            end
         end
         WR_EXEC: state_nx = IDLE;
         RD_EXEC: state_nx = RD_WAIT;
         RD_WAIT: begin
            if (RF_RdData_VLD) begin
               txd_nx    = RF_RdData;
               state_nx  = TX_SEND;
               tx_vld_nx = !TX_BUSY;
            end else if (rd_cnt == RD_LAST) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               rd_cnt_nx = rd_cnt + 1'b1;
            end
         end
         TX_SEND: begin
            // leave once the single TX strobe has been issued
            if (TX_D_VLD) state_nx  = IDLE;
            else          tx_vld_nx = !TX_BUSY;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         to_cnt     <= '0;
         rd_cnt     <= '0;
         RF_WrEn    <= 1'b0;
         RF_RdEn    <= 1'b0;
         RF_Address <= '0;
         RF_WrData  <= '0;
         TX_D       <= '0;
         TX_D_VLD   <= 1'b0;
         CMD_ERR    <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         state      <= state_nx;
         to_cnt     <= to_cnt_nx;
         rd_cnt     <= rd_cnt_nx;
         RF_WrEn    <= (state_nx == WR_EXEC);
         RF_RdEn    <= (state_nx == RD_EXEC);
         RF_Address <= addr_nx;
         RF_WrData  <= wdata_nx;
         TX_D       <= txd_nx;
         TX_D_VLD   <= tx_vld_nx;
         CMD_ERR    <= err_nx;
         BUSY       <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: timed byte frames against a register-file responder,
// with expected strobe cycles and data predicted from the frame rules.
module tb_regfile_cmd_ctrl;

   localparam int TO  = 64;
   localparam int RDT = 8;

   logic       CLK, RST;
   logic [7:0] RX_D;
   logic       RX_D_VLD;
   logic       RF_WrEn, RF_RdEn;
   logic [3:0] RF_Address;
   logic [7:0] RF_WrData, RF_RdData;
   logic       RF_RdData_VLD;
   logic [7:0] TX_D;
   logic       TX_D_VLD, TX_BUSY, CMD_ERR, BUSY;

   typedef struct {int c; int a; int d;} ev_t;

   int   total, bad, cyc, both_hi;
   ev_t  wr_q[$], rd_q[$], tx_q[$];
   int   er_q[$];
   logic [7:0] rf_mem [16];
   logic [7:0] exp_mem[16];
   int   rf_lat, rd_cd;
   bit   rf_auto;
   logic [3:0] rd_addr;

   regfile_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB),
      .TIMEOUT_CYC(TO), .RD_TIMEOUT(RDT)
   ) dut (
      .CLK(CLK), .RST(RST), .RX_D(RX_D), .RX_D_VLD(RX_D_VLD),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .TX_D(TX_D), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .CMD_ERR(CMD_ERR), .BUSY(BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // event recorder and register-file storage, sampled mid-cycle
   initial begin
      forever begin
         @(negedge CLK);
         if (RF_WrEn === 1'b1) begin
            wr_q.push_back('{cyc, int'(RF_Address), int'(RF_WrData)});
            rf_mem[RF_Address] = RF_WrData;
         end
         if (RF_RdEn === 1'b1) begin
            rd_q.push_back('{cyc, int'(RF_Address), 0});
            if (rf_auto) begin
               rd_cd   = rf_lat;
               rd_addr = RF_Address;
            end
         end
         if (TX_D_VLD === 1'b1) tx_q.push_back('{cyc, 0, int'(TX_D)});
         if (CMD_ERR === 1'b1)  er_q.push_back(cyc);
         if (RF_WrEn === 1'b1 && RF_RdEn === 1'b1) both_hi++;
      end
   end

   // read responder: data valid rf_lat cycles after the read strobe
   initial begin
      RF_RdData_VLD = 1'b0;
      RF_RdData     = 8'h00;
      forever begin
         @(posedge CLK);
         #1;
         if (rd_cd > 0) begin
            rd_cd--;
            RF_RdData_VLD = (rd_cd == 0);
            RF_RdData     = rf_mem[rd_addr];
         end else begin
            RF_RdData_VLD = 1'b0;
         end
      end
   end

   function automatic ev_t head(input ev_t q[$]);
      if (q.size() == 0) return '{-1, -1, -1};
      return q[0];
   endfunction

   function automatic int ehead(input int q[$]);
      if (q.size() == 0) return -1;
      return q[0];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b, output int c);
      RX_D     = b;
      RX_D_VLD = 1'b1;
      c        = cyc;
      tick();
      RX_D_VLD = 1'b0;
      RX_D     = 8'($urandom);
   endtask

   task automatic flush();
      wr_q.delete();
      rd_q.delete();
      tx_q.delete();
      er_q.delete();
   endtask

   task automatic test_reset();
      @(negedge CLK);
      total++;
      if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_D, TX_D_VLD, CMD_ERR, BUSY} !== 30'h0) begin
         bad++;
         $display("FAIL reset_held got=%h want=0", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_D, TX_D_VLD, CMD_ERR, BUSY});
      end
      tick();
      RST = 1'b0;
      tick();
      @(negedge CLK);
      total++;
      if ({RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR, BUSY} !== 5'h0) begin
         bad++;
         $display("FAIL reset_release got=%b want=00000", {RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR, BUSY});
      end
      tick();
   endtask

   task automatic test_write();
      int c, cd;
      logic [3:0] a;
      logic [7:0] d;
      ev_t e;
      flush();
      send(8'hAA, c); idle(3); send(8'h05, c); idle(3); send(8'h3C, cd);
      exp_mem[5] = 8'h3C;
      @(negedge CLK);
      total++;
      if (BUSY !== 1'b1) begin bad++; $display("FAIL wr_busy_exec got=%b want=1", BUSY); end
      tick();
      @(negedge CLK);
      total++;
      if (BUSY !== 1'b0) begin bad++; $display("FAIL wr_busy_after got=%b want=0", BUSY); end
      idle(2);
      e = head(wr_q);
      total++;
      if (wr_q.size() !== 1 || e.c !== cd + 1 || e.a !== 5 || e.d !== 'h3C) begin
         bad++;
         $display("FAIL wr_basic got n=%0d cyc=%0d a=%0h d=%0h want n=1 cyc=%0d a=5 d=3c", wr_q.size(), e.c, e.a, e.d, cd + 1);
      end
      total++;
      if (rd_q.size() !== 0 || er_q.size() !== 0) begin
         bad++;
         $display("FAIL wr_side got rd=%0d err=%0d want 0 0", rd_q.size(), er_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         a = 4'($urandom);
         d = 8'($urandom);
         flush();
         send(8'hAA, c); idle($urandom_range(0, 10));
         send({4'h0, a}, c); idle($urandom_range(0, 10));
         send(d, cd);
         exp_mem[a] = d;
         idle(3);
         e = head(wr_q);
         total++;
         if (wr_q.size() !== 1 || e.c !== cd + 1 || e.a !== int'(a) || e.d !== int'(d) || er_q.size() !== 0 || rd_q.size() !== 0) begin
            bad++;
            $display("FAIL wr_rand%0d got n=%0d cyc=%0d a=%0h d=%0h err=%0d want n=1 cyc=%0d a=%0h d=%0h err=0", i, wr_q.size(), e.c, e.a, e.d, er_q.size(), cd + 1, a, d);
         end
      end
   endtask

   task automatic test_read();
      int c, ca, lat;
      logic [3:0] a;
      ev_t e, r;
      for (int i = 0; i < 7; i++) begin
         a   = (i == 0) ? 4'h5 : 4'($urandom);
         lat = (i == 0) ? 1 : (i == 1) ? RDT : $urandom_range(1, RDT);
         rf_lat = lat;
         flush();
         send(8'hBB, c); idle($urandom_range(0, 5));
         send({4'h0, a}, ca);
         idle(lat + 6);
         e = head(tx_q);
         r = head(rd_q);
         total++;
         if (tx_q.size() !== 1 || e.c !== ca + 2 + lat || e.d !== int'(exp_mem[a])) begin
            bad++;
            $display("FAIL rd%0d_tx got n=%0d cyc=%0d d=%0h want n=1 cyc=%0d d=%0h", i, tx_q.size(), e.c, e.d, ca + 2 + lat, exp_mem[a]);
         end
         total++;
         if (rd_q.size() !== 1 || r.c !== ca + 1 || r.a !== int'(a) || wr_q.size() !== 0 || er_q.size() !== 0) begin
            bad++;
            $display("FAIL rd%0d_strobe got n=%0d cyc=%0d a=%0h wr=%0d err=%0d want n=1 cyc=%0d a=%0h wr=0 err=0", i, rd_q.size(), r.c, r.a, wr_q.size(), er_q.size(), ca + 1, a);
         end
      end
      rf_lat = 1;
   endtask

   task automatic test_backpressure();
      int c, ca, ci, k;
      logic [3:0] a;
      ev_t e;
      flush();
      TX_BUSY = 1'b1;
      send(8'hBB, c); send(8'h05, ca);
      idle(9); send(8'hAA, ci); idle(9);
      TX_BUSY = 1'b0;
      tick();
      @(negedge CLK);
      total++;
      if (TX_D_VLD !== 1'b1 || TX_D !== exp_mem[5]) begin
         bad++;
         $display("FAIL bp_pulse got vld=%b d=%h want vld=1 d=%h", TX_D_VLD, TX_D, exp_mem[5]);
      end
      tick();
      @(negedge CLK);
      total++;
      if (BUSY !== 1'b0 || TX_D_VLD !== 1'b0) begin
         bad++;
         $display("FAIL bp_after got busy=%b vld=%b want 0 0", BUSY, TX_D_VLD);
      end
      idle(3);
      e = head(tx_q);
      total++;
      if (tx_q.size() !== 1 || e.c !== ca + 21 || wr_q.size() !== 0 || er_q.size() !== 0) begin
         bad++;
         $display("FAIL bp_events got tx=%0d cyc=%0d wr=%0d err=%0d want tx=1 cyc=%0d wr=0 err=0", tx_q.size(), e.c, wr_q.size(), er_q.size(), ca + 21);
      end
      for (int i = 0; i < 3; i++) begin
         a = 4'($urandom);
         k = $urandom_range(3, 25);
         flush();
         TX_BUSY = 1'b1;
         send(8'hBB, c); send({4'h0, a}, ca);
         idle(k - 1);
         TX_BUSY = 1'b0;
         idle(4);
         e = head(tx_q);
         total++;
         if (tx_q.size() !== 1 || e.c !== ca + k + 1 || e.d !== int'(exp_mem[a])) begin
            bad++;
            $display("FAIL bp_rand%0d got n=%0d cyc=%0d d=%0h want n=1 cyc=%0d d=%0h", i, tx_q.size(), e.c, e.d, ca + k + 1, exp_mem[a]);
         end
      end
   endtask

   task automatic test_errors();
      int c, ca;
      logic [7:0] b;
      flush();
      send(8'h12, c); idle(3);
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== c + 1 || wr_q.size() !== 0 || rd_q.size() !== 0) begin
         bad++;
         $display("FAIL err_opcode got n=%0d cyc=%0d wr=%0d rd=%0d want n=1 cyc=%0d", er_q.size(), ehead(er_q), wr_q.size(), rd_q.size(), c + 1);
      end
      flush();
      send(8'hAA, c); send(8'h15, ca); idle(3);
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== ca + 1 || wr_q.size() !== 0 || BUSY !== 1'b0) begin
         bad++;
         $display("FAIL err_wr_addr got n=%0d cyc=%0d wr=%0d busy=%b want n=1 cyc=%0d", er_q.size(), ehead(er_q), wr_q.size(), BUSY, ca + 1);
      end
      flush();
      send(8'hBB, c); send(8'h80, ca); idle(3);
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== ca + 1 || rd_q.size() !== 0) begin
         bad++;
         $display("FAIL err_rd_addr got n=%0d cyc=%0d rd=%0d want n=1 cyc=%0d", er_q.size(), ehead(er_q), rd_q.size(), ca + 1);
      end
      flush();
      rf_auto = 1'b0;
      send(8'hBB, c); send(8'h02, ca); idle(RDT + 8);
      rf_auto = 1'b1;
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== ca + 2 + RDT || tx_q.size() !== 0 || rd_q.size() !== 1) begin
         bad++;
         $display("FAIL err_rd_timeout got n=%0d cyc=%0d tx=%0d rd=%0d want n=1 cyc=%0d tx=0 rd=1", er_q.size(), ehead(er_q), tx_q.size(), rd_q.size(), ca + 2 + RDT);
      end
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         if (b == 8'hAA || b == 8'hBB) b = 8'h00;
         flush();
         send(b, c); idle(2);
         total++;
         if (er_q.size() !== 1 || ehead(er_q) !== c + 1 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL err_rand%0d op=%h got n=%0d cyc=%0d busy=%b want n=1 cyc=%0d", i, b, er_q.size(), ehead(er_q), BUSY, c + 1);
         end
      end
   endtask

   task automatic test_timeout();
      int c, ca, cd;
      ev_t e;
      flush();
      send(8'hAA, c); send(8'h01, ca); idle(TO + 6);
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== ca + TO + 2 || wr_q.size() !== 0) begin
         bad++;
         $display("FAIL to_data got n=%0d cyc=%0d wr=%0d want n=1 cyc=%0d wr=0", er_q.size(), ehead(er_q), wr_q.size(), ca + TO + 2);
      end
      flush();
      send(8'hAA, c); send(8'h01, ca); idle(TO); send(8'h5A, cd);
      exp_mem[1] = 8'h5A;
      idle(3);
      e = head(wr_q);
      total++;
      if (wr_q.size() !== 1 || e.c !== ca + TO + 2 || e.a !== 1 || e.d !== 'h5A || er_q.size() !== 0) begin
         bad++;
         $display("FAIL to_edge got n=%0d cyc=%0d a=%0h d=%0h err=%0d want n=1 cyc=%0d a=1 d=5a err=0", wr_q.size(), e.c, e.a, e.d, er_q.size(), ca + TO + 2);
      end
      flush();
      send(8'hBB, c); idle(TO + 4);
      total++;
      if (er_q.size() !== 1 || ehead(er_q) !== c + TO + 2 || rd_q.size() !== 0) begin
         bad++;
         $display("FAIL to_rd_addr got n=%0d cyc=%0d rd=%0d want n=1 cyc=%0d", er_q.size(), ehead(er_q), rd_q.size(), c + TO + 2);
      end
   endtask

   task automatic test_reset_mid();
      int c, ca;
      ev_t e;
      flush();
      send(8'hAA, c); send(8'h07, ca);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_D, TX_D_VLD, CMD_ERR, BUSY} !== 30'h0) begin
         bad++;
         $display("FAIL rst_mid_outputs got=%h want=0", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_D, TX_D_VLD, CMD_ERR, BUSY});
      end
      idle(4);
      total++;
      if (wr_q.size() !== 0 || er_q.size() !== 0) begin
         bad++;
         $display("FAIL rst_mid_events got wr=%0d err=%0d want 0 0", wr_q.size(), er_q.size());
      end
      flush();
      send(8'hBB, c); send(8'h00, ca); idle(6);
      e = head(tx_q);
      total++;
      if (tx_q.size() !== 1 || e.c !== ca + 3 || e.d !== int'(exp_mem[0]) || er_q.size() !== 0) begin
         bad++;
         $display("FAIL rst_then_read got n=%0d cyc=%0d d=%0h err=%0d want n=1 cyc=%0d d=%0h err=0", tx_q.size(), e.c, e.d, er_q.size(), ca + 3, exp_mem[0]);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      both_hi  = 0;
      RST      = 1'b1;
      RX_D     = 8'h00;
      RX_D_VLD = 1'b0;
      TX_BUSY  = 1'b0;
      rf_auto  = 1'b1;
      rf_lat   = 1;
      rd_cd    = 0;
      rd_addr  = 4'h0;
      for (int i = 0; i < 16; i++) begin
         rf_mem[i]  = 8'($urandom);
         exp_mem[i] = rf_mem[i];
      end
      idle(3);
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_errors();
      test_timeout();
      test_reset_mid();
      total++;
      if (both_hi !== 0) begin
         bad++;
         $display("FAIL wr_rd_overlap got=%0d want=0", both_hi);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_cmd_ctrl.md
Name: regfile_cmd_ctrl

Overview:
- Byte-stream command controller that sequences the system register file.
- Takes framed command bytes from the receive path (write frame: WR_CMD, addr, data; read frame: RD_CMD, addr).
- Drives the register-file write/read strobes, captures read data and hands it to the transmit path.
- Sits between the RX deserializer, the register file and the TX serializer. It is the only master of the register-file port.

Parameters:
- DATA_WIDTH, 8: byte/data width.
- ADDR_WIDTH, 4: register-file address width.
- WR_CMD, 8'hAA: write-frame opcode.
- RD_CMD, 8'hBB: read-frame opcode.
- TIMEOUT_CYC, 64: max idle cycles between bytes of one frame.
- RD_TIMEOUT, 8: max cycles from RF_RdEn to RF_RdData_VLD.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RX_D  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe, RX_D valid.
- RF_WrEn  out  1  register-file write strobe.
- RF_RdEn  out  1  register-file read strobe.
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrData  out  DATA_WIDTH  register-file write data.
- RF_RdData  in  DATA_WIDTH  register-file read data.
- RF_RdData_VLD  in  1  read data valid.
- TX_D  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle strobe, TX_D valid.
- TX_BUSY  in  1  transmitter busy.
- CMD_ERR  out  1  one-cycle error pulse.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- One clock domain.
- RST is sampled on the CLK rising edge, active-high, and overrides everything. It aborts any frame mid-operation; no partial write or TX is issued afterwards.
- All outputs are registered. Reset values: RF_WrEn=0, RF_RdEn=0, RF_Address=0, RF_WrData=0, TX_D=0, TX_D_VLD=0, CMD_ERR=0, BUSY=0, state=IDLE, counters=0.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE, on RX_D_VLD:
  - RX_D==WR_CMD -> WR_ADDR.
  - RX_D==RD_CMD -> RD_ADDR.
  - Any other value -> CMD_ERR pulses next cycle; stay IDLE.
- Address byte (WR_ADDR or RD_ADDR), on RX_D_VLD:
  - If RX_D[DATA_WIDTH-1:ADDR_WIDTH] != 0 -> CMD_ERR pulse, go to IDLE.
  - Else latch RF_Address = RX_D[ADDR_WIDTH-1:0]. WR_ADDR -> WR_DATA; RD_ADDR -> RD_EXEC.
- WR_DATA, on RX_D_VLD: latch RF_WrData = RX_D, go to WR_EXEC.
- WR_EXEC: RF_WrEn=1 for exactly one cycle, then IDLE.
  - Write latency: RF_WrEn is high the cycle after the data byte strobe.
- RD_EXEC: RF_RdEn=1 for exactly one cycle (the cycle after the address strobe), then RD_WAIT.
- RD_WAIT:
  - On RF_RdData_VLD: latch TX_D = RF_RdData, go to TX_SEND.
  - If RF_RdData_VLD has not arrived within RD_TIMEOUT cycles of entering RD_WAIT: CMD_ERR pulse, IDLE, nothing transmitted.
- TX_SEND:
  - Wait while TX_BUSY=1.
  - On the first cycle TX_BUSY=0, assert TX_D_VLD for one cycle (TX_D stable), then IDLE.
  - Read turnaround, TX not busy: RD_CMD addr strobe @N -> RF_RdEn @N+1 -> RdData_VLD @N+2 -> TX_D_VLD @N+3.
- RF_WrEn and RF_RdEn are never high in the same cycle. RF_Address and RF_WrData hold their last values between frames.
- Inter-byte timeout:
  - Applies in WR_ADDR, WR_DATA and RD_ADDR.
  - The counter clears on entering these states and on every accepted byte, and increments otherwise.
  - On reaching TIMEOUT_CYC: CMD_ERR pulse, IDLE, frame discarded, no strobe issued.
  - If RX_D_VLD arrives in the same cycle the counter expires, the byte wins.
  - Counter width: $clog2(TIMEOUT_CYC+1).
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: the byte is dropped silently; no state change, no CMD_ERR.
- CMD_ERR is always a single-cycle pulse, and at most one pulse per frame.

Test Plan:
- Write: RX 0xAA, 0x05, 0x3C (gaps of 3 cycles) -> RF_WrEn high exactly one cycle after the 0x3C strobe with RF_Address=5, RF_WrData=0x3C; RF_RdEn stays 0; BUSY low next cycle.
- Read: RX 0xBB, 0x05, RF model returns 0x3C one cycle after RdEn, TX_BUSY=0 -> TX_D_VLD pulse with TX_D=0x3C three cycles after the address strobe.
- Backpressure: same read with TX_BUSY=1 for 20 cycles -> TX_D_VLD held off, then a single pulse on the first TX_BUSY=0 cycle; a 0xAA byte injected during TX_SEND is ignored and no write occurs.
- Errors, each returning to IDLE with a single CMD_ERR pulse and no RF strobe:
  - opcode 0x12;
  - 0xAA then address 0x15;
  - 0xBB, 0x02 with RF_RdData_VLD never asserted (pulse RD_TIMEOUT cycles after RD_WAIT entry).
- Timeout: 0xAA, 0x01, then silence for TIMEOUT_CYC cycles -> CMD_ERR pulse, no RF_WrEn. Repeat with the data byte arriving exactly on the expiry cycle -> write of that byte completes, no CMD_ERR.
- Reset: assert RST for one cycle between the address and data bytes of a write frame -> all outputs at reset values next cycle, no RF_WrEn. A following full read frame 0xBB, 0x00 completes normally.
